add_not_unit: RTL and testbench

//   Registered 32-bit add/complement unit for the datapath ALU.

---
 rtl/add_not_unit_if.sv | 24 ++
 rtl/add_not_unit.sv | 113 +++++++++++
 tb/tb_add_not_unit.sv | 169 ++++++++++++++++
 3 files changed

// File: rtl/add_not_unit_if.sv
// Operand/result bundle for the registered add/complement unit.
// The master drives operands and op; the slave returns registered results.
interface add_not_unit_if #(
   parameter int WIDTH = 32
);
   logic             in_valid;
   logic [1:0]       op;
   logic [WIDTH-1:0] Ra;
   logic [WIDTH-1:0] Rb;
   logic             cin;
   logic [WIDTH-1:0] Rz;
   logic             cout;
   logic             out_valid;

   modport master (
      output in_valid, op, Ra, Rb, cin,
      input  Rz, cout, out_valid
   );

   modport slave (
      input  in_valid, op, Ra, Rb, cin,
      output Rz, cout, out_valid
   );
endinterface

// File: rtl/add_not_unit.sv
// Registered add/complement unit: ADD, NOT, NEG and SUB share one carry-lookahead
// adder whose operands are pre-conditioned by a complement stage; one-cycle latency.
module add_not_unit #(
   parameter int WIDTH = 32
) (
   input  logic         clk,
   input  logic         clr,
   add_not_unit_if.slave bus
);

   typedef enum logic [1:0] {
      OP_ADD = 2'b00,
      OP_NOT = 2'b01,
      OP_NEG = 2'b10,
      OP_SUB = 2'b11
   } op_e;

   localparam int NGRP = WIDTH / 4;

   logic [WIDTH-1:0] add_a;
   logic [WIDTH-1:0] add_b;
   logic             add_cin;
   logic [WIDTH-1:0] add_sum;
   logic [NGRP:0]    grp_c;

   logic [WIDTH-1:0] rz_q, rz_d;
   logic             cout_q, cout_d;
   logic             out_valid_q, out_valid_d;

   // Operand conditioning: NOT/NEG are ~Ra (+0 or +1) with Rb forced to zero,
   // so Rb never reaches the adder for those ops.
   always_comb begin
      add_a   = bus.Ra;
      add_b   = bus.Rb;
      add_cin = bus.cin;
      unique case (op_e'(bus.op))
         OP_ADD: begin
            add_a   = bus.Ra;
            add_b   = bus.Rb;
            add_cin = bus.cin;
         end
         OP_NOT: begin
            add_a   = ~bus.Ra;
            add_b   = '0;
            add_cin = 1'b0;
         end
         OP_NEG: begin
            add_a   = ~bus.Ra;
            add_b   = '0;
            add_cin = 1'b1;
         end
         OP_SUB: begin
            add_a   = bus.Ra;
            add_b   = ~bus.Rb;
            add_cin = 1'b1;
         end
         default: ;
      endcase
   end

   assign grp_c[0] = add_cin;

   // Eight 4-bit lookahead groups; group carries ripple from one to the next.
   for (genvar g = 0; g < NGRP; g++) begin : g_cla
      logic [3:0] gg;
      logic [3:0] pp;
      logic [4:0] c;

      assign gg   = add_a[4*g +: 4] & add_b[4*g +: 4];
      assign pp   = add_a[4*g +: 4] ^ add_b[4*g +: 4];
      assign c[0] = grp_c[g];
      assign c[1] = gg[0] | (pp[0] & c[0]);
      assign c[2] = gg[1] | (pp[1] & gg[0]) | (pp[1] & pp[0] & c[0]);
      assign c[3] = gg[2] | (pp[2] & gg[1]) | (pp[2] & pp[1] & gg[0])
                  | (pp[2] & pp[1] & pp[0] & c[0]);
      assign c[4] = gg[3] | (pp[3] & gg[2]) | (pp[3] & pp[2] & gg[1])
                  | (pp[3] & pp[2] & pp[1] & gg[0])
                  | (pp[3] & pp[2] & pp[1] & pp[0] & c[0]);

      assign add_sum[4*g +: 4] = pp ^ c[3:0];
      assign grp_c[g+1]        = c[4];
   end

   // Invalid cycles hold the last result; only the valid flag follows the input.
   always_comb begin
      rz_d        = rz_q;
      cout_d      = cout_q;
      out_valid_d = bus.in_valid;
      if (bus.in_valid) begin
         rz_d   = add_sum;
         cout_d = grp_c[NGRP];
      end
   end

   // NOTE: state registers use non-blocking assignments so every flop samples
   // pre-edge values; reset is asynchronous and clears outputs without a clock.
   always_ff @(posedge clk or negedge clr) begin
      if (!clr) begin
         rz_q        <= '0;
         cout_q      <= 1'b0;
         out_valid_q <= 1'b0;
      end else begin
         rz_q        <= rz_d;
         cout_q      <= cout_d;
         out_valid_q <= out_valid_d;
      end
   end

   assign bus.Rz        = rz_q;
   assign bus.cout      = cout_q;
   assign bus.out_valid = out_valid_q;

endmodule

// File: tb/tb_add_not_unit.sv
// Directed-vector bench for add_not_unit: table of ops with hand-computed results,
// plus hand-written sequences for async reset and valid gating.
module tb_add_not_unit;

   localparam logic [1:0] ADD = 2'b00;
   localparam logic [1:0] NOT = 2'b01;
   localparam logic [1:0] NEG = 2'b10;
   localparam logic [1:0] SUB = 2'b11;

   typedef struct {
      logic [1:0]  op;
      logic [31:0] ra;
      logic [31:0] rb;
      logic        cin;
      logic [31:0] rz;
      logic        cout;
   } vec_t;

   localparam int NVEC = 14;

   logic clk;
   logic clr;
   int   tests;
   int   failures;

   logic [31:0] prev_rz;
   logic        prev_cout;
   logic        prev_ov;

   vec_t vecs [NVEC];

   add_not_unit_if #(.WIDTH(32)) bus ();

   add_not_unit #(.WIDTH(32)) dut (
      .clk (clk),
      .clr (clr),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   task automatic drive(input logic v, input logic [1:0] op, input logic [31:0] ra,
                        input logic [31:0] rb, input logic cin);
      bus.in_valid = v;
      bus.op       = op;
      bus.Ra       = ra;
      bus.Rb       = rb;
      bus.cin      = cin;
   endtask

   initial begin
      tests    = 0;
      failures = 0;

      //              op   ra            rb            cin   rz            cout
      vecs[0]  = '{NEG, 32'h00000000, 32'hFFFFFFFF, 1'b1, 32'h00000000, 1'b1};
      vecs[1]  = '{NEG, 32'hAAAAAAAA, 32'h12345678, 1'b1, 32'h55555556, 1'b0};
      vecs[2]  = '{NEG, 32'hFFFFFFFF, 32'h00000000, 1'b0, 32'h00000001, 1'b0};
      vecs[3]  = '{NOT, 32'hAAAAAAAA, 32'hFFFFFFFF, 1'b1, 32'h55555555, 1'b0};
      vecs[4]  = '{NOT, 32'h00000000, 32'h00000001, 1'b0, 32'hFFFFFFFF, 1'b0};
      vecs[5]  = '{ADD, 32'hFFFFFFFF, 32'h00000000, 1'b1, 32'h00000000, 1'b1};
      vecs[6]  = '{ADD, 32'h00000005, 32'h00000007, 1'b0, 32'h0000000C, 1'b0};
      vecs[7]  = '{ADD, 32'h0000FFFF, 32'h00000001, 1'b1, 32'h00010001, 1'b0};
      vecs[8]  = '{SUB, 32'h0000000A, 32'h00000003, 1'b0, 32'h00000007, 1'b1};
      vecs[9]  = '{SUB, 32'h00000003, 32'h0000000A, 1'b1, 32'hFFFFFFF9, 1'b0};
      vecs[10] = '{NEG, 32'h80000000, 32'hFFFFFFFF, 1'b1, 32'h80000000, 1'b0};
      vecs[11] = '{ADD, 32'h80000000, 32'h80000000, 1'b0, 32'h00000000, 1'b1};
      vecs[12] = '{SUB, 32'h00000005, 32'h00000005, 1'b0, 32'h00000000, 1'b1};
      vecs[13] = '{ADD, 32'h12345678, 32'h87654321, 1'b0, 32'h99999999, 1'b0};

      // Reset held across edges
      clr = 1'b0;
      drive(1'b0, ADD, 32'h0, 32'h0, 1'b0);
      repeat (2) @(posedge clk);
      #1;
      check("reset rz", bus.Rz, 32'h0);
      check("reset cout", 32'(bus.cout), 32'h0);
      check("reset out_valid", 32'(bus.out_valid), 32'h0);

      // Async reset with a result in flight
      @(negedge clk);
      clr = 1'b1;
      drive(1'b1, ADD, 32'h00001234, 32'h0, 1'b0);
      @(posedge clk);
      #1;
      check("pre-reset rz", bus.Rz, 32'h00001234);
      check("pre-reset out_valid", 32'(bus.out_valid), 32'h1);
      #2 clr = 1'b0;
      #1;
      check("async reset rz", bus.Rz, 32'h0);
      check("async reset cout", 32'(bus.cout), 32'h0);
      check("async reset out_valid", 32'(bus.out_valid), 32'h0);
      @(posedge clk);
      #1;
      check("reset hold rz", bus.Rz, 32'h0);
      check("reset hold out_valid", 32'(bus.out_valid), 32'h0);

      // First edge after release captures what is presented
      @(negedge clk);
      clr = 1'b1;
      drive(1'b1, NOT, 32'h0F0F0F0F, 32'h0, 1'b0);
      @(posedge clk);
      #1;
      check("release capture rz", bus.Rz, 32'hF0F0F0F0);
      check("release capture out_valid", 32'(bus.out_valid), 32'h1);
      prev_rz   = 32'hF0F0F0F0;
      prev_cout = 1'b0;
      prev_ov   = 1'b1;

      // Back-to-back vectors: output only changes after the capturing edge
      for (int i = 0; i < NVEC; i++) begin
         @(negedge clk);
         drive(1'b1, vecs[i].op, vecs[i].ra, vecs[i].rb, vecs[i].cin);
         #4;
         check($sformatf("vec%0d latency rz", i), bus.Rz, prev_rz);
         check($sformatf("vec%0d latency out_valid", i), 32'(bus.out_valid), 32'(prev_ov));
         @(posedge clk);
         #1;
         check($sformatf("vec%0d rz", i), bus.Rz, vecs[i].rz);
         check($sformatf("vec%0d cout", i), 32'(bus.cout), 32'(vecs[i].cout));
         check($sformatf("vec%0d out_valid", i), 32'(bus.out_valid), 32'h1);
         prev_rz   = vecs[i].rz;
         prev_cout = vecs[i].cout;
         prev_ov   = 1'b1;
      end

      // Valid gating: 1,0,1 with hold of Rz/cout in the idle cycle
      @(negedge clk);
      drive(1'b1, ADD, 32'hFFFFFFFF, 32'h0, 1'b1);
      @(posedge clk);
      #1;
      check("gate1 rz", bus.Rz, 32'h0);
      check("gate1 cout", 32'(bus.cout), 32'h1);
      check("gate1 out_valid", 32'(bus.out_valid), 32'h1);
      @(negedge clk);
      drive(1'b0, ADD, 32'h00000001, 32'h00000001, 1'b0);
      @(posedge clk);
      #1;
      check("gate0 rz hold", bus.Rz, 32'h0);
      check("gate0 cout hold", 32'(bus.cout), 32'h1);
      check("gate0 out_valid", 32'(bus.out_valid), 32'h0);
      @(negedge clk);
      drive(1'b1, ADD, 32'h00000002, 32'h00000002, 1'b0);
      @(posedge clk);
      #1;
      check("gate2 rz", bus.Rz, 32'h4);
      check("gate2 cout", 32'(bus.cout), 32'h0);
      check("gate2 out_valid", 32'(bus.out_valid), 32'h1);

      @(negedge clk);
      drive(1'b0, ADD, 32'h0, 32'h0, 1'b0);
      @(posedge clk);
      #1;
      check("idle out_valid", 32'(bus.out_valid), 32'h0);

      $display("[TB] %0d tests run, %0d failed", tests, failures);
      $finish;
   end

endmodule
